// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: key codes, FSM states and
// buffer entry layout helpers.
package note_sequencer_pkg;

  localparam logic [1:0] KEY_NONE = 2'b00;
  localparam logic [1:0] KEY_DO   = 2'b01;
  localparam logic [1:0] KEY_RE   = 2'b10;
  localparam logic [1:0] KEY_MI   = 2'b11;

  localparam int unsigned KEY_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RECORD = 2'b01,
    ST_PLAY   = 2'b10
  } state_e;

  // Entry layout, MSB first: {key, offset, duration}.
  function automatic int unsigned entry_width(input int unsigned tw);
    return KEY_W + 2 * tw;
  endfunction

endpackage

// File: rtl/note_sequencer_mem.sv
// Event buffer: register array with synchronous write and asynchronous read.
// Contents are not reset.
module note_sequencer_mem #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned W     = 28
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/note_sequencer.sv
// Records key events as offsets from the first event and replays them as a
// single-voice key stream against a 0.01 s play clock.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned TW    = 13
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tick,
  input  logic          rec_start,
  input  logic          play_start,
  input  logic          stop,
  input  logic          ev_valid,
  input  logic [1:0]    ev_key,
  input  logic [TW-1:0] ev_start,
  input  logic [TW-1:0] ev_dur,
  output logic [1:0]    play_key,
  output logic          rec_busy,
  output logic          play_busy,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          done
);

  localparam int unsigned EW = entry_width(TW);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  state_e        state_q;
  logic [AW:0]   count_q;
  logic [AW:0]   rd_ptr_q;
  logic [TW-1:0] ptime_q;
  logic [TW-1:0] remaining_q;
  logic [TW-1:0] base_q;
  logic          first_seen_q;
  logic [1:0]    key_q;
  logic          overflow_q;
  logic          done_q;

  logic          any_cmd;
  logic          ev_ok;
  logic          full;
  logic          wr_en;
  logic [TW-1:0] wr_offset;
  logic [EW-1:0] wr_data;
  logic [EW-1:0] rd_data;
  logic [1:0]    rd_key;
  logic [TW-1:0] rd_offset;
  logic [TW-1:0] rd_dur;
  logic          issue;

  always_comb begin
    any_cmd   = stop | rec_start | play_start;
    ev_ok     = (state_q == ST_RECORD) && ev_valid && (ev_key != KEY_NONE) && !any_cmd;
    full      = (count_q == FULL_COUNT);
    wr_en     = ev_ok && !full;
    // Wrapping subtraction keeps offsets correct across a system-time rollover.
    wr_offset = first_seen_q ? (ev_start - base_q) : '0;
    wr_data   = {ev_key, wr_offset, ev_dur};
  end

  note_sequencer_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (EW)
  ) u_mem (
    .clock (clock),
    .we    (wr_en),
    .waddr (count_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    rd_key    = rd_data[EW-1 -: 2];
    rd_offset = rd_data[2*TW-1 -: TW];
    rd_dur    = rd_data[TW-1:0];
    issue     = (state_q == ST_PLAY) && (rd_ptr_q < count_q) && (ptime_q >= rd_offset);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      ptime_q      <= '0;
      remaining_q  <= '0;
      base_q       <= '0;
      first_seen_q <= 1'b0;
      key_q        <= KEY_NONE;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q <= ST_IDLE;
        key_q   <= KEY_NONE;
      end else if (rec_start) begin
        state_q      <= ST_RECORD;
        count_q      <= '0;
        overflow_q   <= 1'b0;
        first_seen_q <= 1'b0;
        key_q        <= KEY_NONE;
      end else if (play_start && (state_q == ST_IDLE) && (count_q != '0)) begin
        state_q     <= ST_PLAY;
        rd_ptr_q    <= '0;
        ptime_q     <= '0;
        remaining_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
          end
          ST_RECORD: begin
            if (ev_ok) begin
              if (full) begin
                overflow_q <= 1'b1;
              end else begin
                count_q <= count_q + 1'b1;
                if (!first_seen_q) begin
                  base_q       <= ev_start;
                  first_seen_q <= 1'b1;
                end
              end
            end
          end
          ST_PLAY: begin
            if (tick && (ptime_q != '1)) begin
              ptime_q <= ptime_q + 1'b1;
            end
            if (issue) begin
              key_q       <= rd_key;
              remaining_q <= (rd_dur == '0) ? TW'(1) : rd_dur;
              rd_ptr_q    <= rd_ptr_q + 1'b1;
            end else if ((rd_ptr_q == count_q) && (remaining_q == '0)) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else if (tick && (remaining_q != '0)) begin
              remaining_q <= remaining_q - 1'b1;
              if (remaining_q == TW'(1)) begin
                key_q <= KEY_NONE;
              end
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign play_key  = key_q;
  assign rec_busy  = (state_q == ST_RECORD);
  assign play_busy = (state_q == ST_PLAY);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign done      = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: expected key transitions are queued when
// a recording is made and checked as the DUT plays them back.
module tb_note_sequencer;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned TW    = 13;

  logic          clock = 1'b0;
  logic          reset;
  logic          tick;
  logic          rec_start;
  logic          play_start;
  logic          stop;
  logic          ev_valid;
  logic [1:0]    ev_key;
  logic [TW-1:0] ev_start;
  logic [TW-1:0] ev_dur;
  logic [1:0]    play_key;
  logic          rec_busy;
  logic          play_busy;
  logic [AW:0]   count;
  logic          overflow;
  logic          done;

  note_sequencer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .TW    (TW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .rec_start  (rec_start),
    .play_start (play_start),
    .stop       (stop),
    .ev_valid   (ev_valid),
    .ev_key     (ev_key),
    .ev_start   (ev_start),
    .ev_dur     (ev_dur),
    .play_key   (play_key),
    .rec_busy   (rec_busy),
    .play_busy  (play_busy),
    .count      (count),
    .overflow   (overflow),
    .done       (done)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [1:0] key;
    int         ticks;
    bit         chk;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         abs_ticks = 0;
  int         mark = 0;
  int         done_seen = 0;
  bit         tick_en = 1'b0;
  logic [1:0] last_key = 2'b00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] key, input int ticks, input bit chk);
    exp_t e;
    e.key   = key;
    e.ticks = ticks;
    e.chk   = chk;
    q.push_back(e);
  endtask

  // One clock: sample at the falling edge, score key changes, set next tick.
  task automatic step();
    exp_t e;
    @(negedge clock);
    if (tick) abs_ticks++;
    if (done) done_seen++;
    if (play_key !== last_key) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_key_change: got %0d expected %0d", play_key, last_key);
      end else begin
        e = q.pop_front();
        check("play_key", 32'(play_key), 32'(e.key));
        if (e.chk) check("ticks_before_change", 32'(abs_ticks - mark), 32'(e.ticks));
      end
      mark     = abs_ticks;
      last_key = play_key;
    end
    cyc++;
    tick = tick_en && ((cyc % 4) == 0);
  endtask

  task automatic pulse_rec();
    rec_start = 1'b1;
    step();
    rec_start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic send_ev(input logic [1:0] key, input int start, input int dur);
    ev_key   = key;
    ev_start = TW'(start);
    ev_dur   = TW'(dur);
    ev_valid = 1'b1;
    step();
    ev_valid = 1'b0;
  endtask

  task automatic play_and_wait(input string tag);
    int d0;
    d0 = done_seen;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    check({tag, "_play_busy"}, 32'(play_busy), 32'd1);
    step();
    tick_en = 1'b1;
    for (int i = 0; i < 3000 && play_busy; i++) step();
    tick_en = 1'b0;
    check({tag, "_finished"}, 32'(play_busy), 32'd0);
    check({tag, "_done_pulses"}, 32'(done_seen - d0), 32'd1);
    check({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    reset      = 1'b1;
    tick       = 1'b0;
    rec_start  = 1'b0;
    play_start = 1'b0;
    stop       = 1'b0;
    ev_valid   = 1'b0;
    ev_key     = 2'b00;
    ev_start   = '0;
    ev_dur     = '0;
    repeat (2) @(negedge clock);
    check("rst_play_key", 32'(play_key), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'({rec_busy, play_busy}), 32'd0);
    reset = 1'b0;
    step();

    // play_start with an empty buffer stays idle
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    step();
    check("empty_play_ignored", 32'({rec_busy, play_busy}), 32'd0);

    // Record then play, including an equal-offset preemption
    pulse_rec();
    check("rec_busy", 32'(rec_busy), 32'd1);
    send_ev(2'b01, 100, 20);
    check("count_after_first", 32'(count), 32'd1);
    send_ev(2'b10, 150, 10);
    send_ev(2'b11, 150, 5);
    check("count_three", 32'(count), 32'd3);
    pulse_stop();
    check("rec_stopped", 32'(rec_busy), 32'd0);
    push(2'b01, 0, 1'b0);
    push(2'b00, 20, 1'b1);
    push(2'b10, 30, 1'b1);
    push(2'b11, 0, 1'b1);
    push(2'b00, 5, 1'b1);
    play_and_wait("basic");

    // System-time wrap between events
    pulse_rec();
    send_ev(2'b01, 8190, 3);
    send_ev(2'b10, 5, 3);
    pulse_stop();
    check("wrap_count", 32'(count), 32'd2);
    push(2'b01, 0, 1'b0);
    push(2'b00, 3, 1'b1);
    push(2'b10, 4, 1'b1);
    push(2'b00, 3, 1'b1);
    play_and_wait("wrap");

    // Overflow: DEPTH+2 events, only the first DEPTH are kept
    pulse_rec();
    for (int i = 0; i < DEPTH + 2; i++) begin
      send_ev(2'((i % 3) + 1), 2 * i, 1);
      if (i < DEPTH) begin
        push(2'((i % 3) + 1), 1, i != 0);
        push(2'b00, 1, 1'b1);
      end
    end
    check("ovf_count", 32'(count), 32'(DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    send_ev(2'b01, 200, 1);
    check("ovf_count_stays", 32'(count), 32'(DEPTH));
    pulse_stop();
    play_and_wait("overflow");

    // Event coincident with stop is dropped; key 00 ignored; dur 0 lasts one tick
    pulse_rec();
    check("rec_clears_overflow", 32'(overflow), 32'd0);
    check("rec_clears_count", 32'(count), 32'd0);
    ev_key   = 2'b01;
    ev_start = TW'(10);
    ev_dur   = TW'(4);
    ev_valid = 1'b1;
    stop     = 1'b1;
    step();
    ev_valid = 1'b0;
    stop     = 1'b0;
    check("ev_with_stop_dropped", 32'(count), 32'd0);
    check("stop_to_idle", 32'(rec_busy), 32'd0);
    pulse_rec();
    send_ev(2'b00, 20, 4);
    check("key_none_ignored", 32'(count), 32'd0);
    send_ev(2'b11, 30, 0);
    check("dur0_count", 32'(count), 32'd1);
    pulse_stop();
    push(2'b11, 0, 1'b0);
    push(2'b00, 1, 1'b1);
    play_and_wait("dur0");

    // stop mid-note
    pulse_rec();
    send_ev(2'b01, 0, 50);
    pulse_stop();
    push(2'b01, 0, 1'b0);
    d0 = done_seen;
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    step();
    tick_en = 1'b1;
    repeat (20) step();
    push(2'b00, 0, 1'b0);
    pulse_stop();
    tick_en = 1'b0;
    check("stop_key_silent", 32'(play_key), 32'd0);
    check("stop_idle", 32'({rec_busy, play_busy}), 32'd0);
    repeat (3) step();
    check("stop_no_done", 32'(done_seen - d0), 32'd0);
    check("stop_queue_empty", 32'(q.size()), 32'd0);

    // Reset during a sounding note
    pulse_rec();
    send_ev(2'b10, 0, 50);
    pulse_stop();
    push(2'b10, 0, 1'b0);
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    step();
    tick_en = 1'b1;
    repeat (10) step();
    push(2'b00, 0, 1'b0);
    reset = 1'b1;
    step();
    reset   = 1'b0;
    tick_en = 1'b0;
    check("rstplay_key", 32'(play_key), 32'd0);
    check("rstplay_count", 32'(count), 32'd0);
    check("rstplay_busy", 32'({rec_busy, play_busy}), 32'd0);
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    step();
    check("rstplay_play_ignored", 32'(play_busy), 32'd0);
    check("rstplay_queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
